gpio_debounce: RTL and testbench
================================

Name: gpio_debounce

Overview:
- Upstream conditioning stage between raw board push-buttons and the SoC GPIO input bus (`gpio_i`) on the FPGA top level.
- Each channel gets a 2-flop synchroniser, a tick-based stability filter and edge-pulse generation.
- Removes metastability and contact bounce so firmware sees one clean transition per press or release.
- A shared prescaler produces a slow tick, which keeps the per-channel counters narrow.

Parameters:
- NumChannels, 3, number of independent button channels.
- TickDiv, 600, clk_i cycles per filter tick (100 us at 6 MHz); legal range >= 1.
- StableTicks, 50, consecutive ticks of disagreement needed before accepting a new level (5 ms); legal range >= 1.
- ResetLevel, 1'b0, idle level of every button; reset value of synchroniser flops and filtered state.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- btn_i  input  NumChannels  raw asynchronous button levels.
- btn_o  output  NumChannels  debounced levels, fed to the SoC GPIO input bus.
- rise_o  output  NumChannels  one-cycle pulse when btn_o goes 0->1.
- fall_o  output  NumChannels  one-cycle pulse when btn_o goes 1->0.
- tick_o  output  1  prescaler tick, exported for observation.

Behaviour:
- Reset (asynchronous assert, release synchronous to clk_i):
  - sync flops and btn_o = ResetLevel; rise_o = fall_o = 0.
  - prescaler count = 0; all channel counters = 0; tick_o = 0.
- Prescaler:
  - count runs 0..TickDiv-1 and wraps to 0.
  - tick_o = 1 exactly when count == TickDiv-1.
  - With TickDiv=1, tick_o is high every cycle after reset.
  - First tick is at cycle TickDiv-1 after reset release.
- Synchroniser: s1 <= btn_i, s2 <= s1; s2 is the sampled level (2-cycle latency).
- Filter, per channel, evaluated every clk_i edge:
  - s2 == btn_o: counter <= 0, regardless of tick.
  - s2 != btn_o, tick low: counter holds.
  - s2 != btn_o, tick high, counter < StableTicks-1: counter increments.
  - s2 != btn_o, tick high, counter == StableTicks-1: btn_o <= s2, counter <= 0, and in the same cycle the matching rise_o or fall_o is registered high for one cycle.
- Counter width: $clog2(StableTicks+1); it never exceeds StableTicks-1.
- Accept latency from a stable btn_i change to btn_o: between 2+(StableTicks-1)*TickDiv+1 and 2+StableTicks*TickDiv cycles, depending on tick phase.
- Bounce: any return of s2 to btn_o before acceptance clears the counter; no output change and no pulse.
- Pulses are registered and are never high for two consecutive cycles on the same channel. rise_o and fall_o are mutually exclusive per channel.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count aborts the count: btn_o returns to ResetLevel and any pending pulse is dropped.
- Elaboration error if TickDiv < 1 or StableTicks < 1.

Decomposition:
- Shared package gpio_debounce_pkg: default constants TICK_DIV_6MHZ_100US=600 and STABLE_TICKS_5MS=50, plus a function computing counter widths.
- Sub-module debounce_tick_gen (parameter TickDiv; ports clk_i, rst_i, tick_o), instanced once.
- The per-channel filter is a generate loop inside gpio_debounce, not a separate module.

Test Plan (TickDiv=4, StableTicks=3, NumChannels=3, ResetLevel=0 unless stated):
- Reset check: hold rst_i, toggle btn_i -> btn_o=000, rise_o=fall_o=000, tick_o=0. Release -> tick_o high at cycles 3, 7, 11, ...
- Clean press: btn_i[0] 0->1 and held -> btn_o[0]=1 within 11..14 cycles; rise_o[0] high exactly 1 cycle, aligned with the btn_o change; fall_o stays 0.
- Bounce: btn_i[1] toggles every 5 cycles for 60 cycles, then held 1 -> no btn_o[1] change and no pulse during the toggling; exactly one rise_o[1] after it settles.
- Release and simultaneous events: channels 0 and 2 both high, drop both in the same cycle -> fall_o=101 in a single cycle; channel 1 unaffected.
- Reset mid-operation: assert rst_i with counter at 2 and btn_i[0]=1 -> btn_o[0]=0, no pulse. After release with btn_i held 1 -> a full acceptance window elapses before rise_o[0].
- Edge parameters: TickDiv=1, StableTicks=1 -> btn_o follows a btn_i step 3 cycles after it; ResetLevel=1 -> btn_o=111 out of reset and no spurious fall_o.

Source files
------------

// File: rtl/gpio_debounce_pkg.sv
// Shared constants and helpers for the push-button debounce block.
// Defaults give a 100 us filter tick and a 5 ms acceptance window at 6 MHz.
package gpio_debounce_pkg;

    localparam int TICK_DIV_6MHZ_100US = 600;
    localparam int STABLE_TICKS_5MS    = 50;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    // Bits needed to hold values 0..num_values-1; never narrower than one bit.
    function automatic int cnt_width(input int num_values);
        return (num_values <= 1) ? 1 : $clog2(num_values);
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running prescaler shared by all channels; tick_o is high for one
// cycle out of every TickDiv.
module debounce_tick_gen
    import gpio_debounce_pkg::*;
#(
    parameter int TickDiv = TICK_DIV_6MHZ_100US
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int              CntW   = cnt_width(TickDiv);
    localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

    if (TickDiv < 1) begin : g_bad_tick_div
        $error("debounce_tick_gen: TickDiv must be >= 1");
    end

    logic [CntW-1:0] count_reg;
    logic [CntW-1:0] count_next;
    logic            tick_reg;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (count_reg == CntMax) begin
            count_next = '0;
        end
    end

    // The tick is registered from the next count so it is low during reset
    // yet still coincides with count == TickDiv-1 afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            tick_reg  <= (count_next == CntMax);
        end
    end

    assign tick_o = tick_reg;

endmodule

// File: rtl/gpio_debounce.sv
// Push-button conditioner: per-channel 2-flop synchroniser, tick-based
// stability filter and registered rise/fall pulses.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int   NumChannels = 3,
    parameter int   TickDiv     = TICK_DIV_6MHZ_100US,
    parameter int   StableTicks = STABLE_TICKS_5MS,
    parameter logic ResetLevel  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumChannels-1:0] btn_i,
    output logic [NumChannels-1:0] btn_o,
    output logic [NumChannels-1:0] rise_o,
    output logic [NumChannels-1:0] fall_o,
    output logic                   tick_o
);

    localparam int              CntW    = cnt_width(StableTicks + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

    if (StableTicks < 1) begin : g_bad_stable_ticks
        $error("gpio_debounce: StableTicks must be >= 1");
    end

    logic                   tick;
    logic [NumChannels-1:0] s1_reg;
    logic [NumChannels-1:0] s2_reg;

    debounce_tick_gen #(
        .TickDiv (TickDiv)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_reg <= {NumChannels{ResetLevel}};
            s2_reg <= {NumChannels{ResetLevel}};
        end else begin
            s1_reg <= btn_i;
            s2_reg <= s1_reg;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        logic [CntW-1:0] cnt_reg;
        logic [CntW-1:0] cnt_next;
        logic            level_reg;
        logic            level_next;
        logic            rise_reg;
        logic            fall_reg;
        edge_e           edge_next;

        // Any sample agreeing with the accepted level restarts the window,
        // so a bouncing contact never accumulates enough ticks.
        always_comb begin
            cnt_next   = cnt_reg;
            level_next = level_reg;
            edge_next  = EDGE_NONE;
            if (s2_reg[gi] == level_reg) begin
                cnt_next = '0;
            end else if (tick) begin
                if (cnt_reg == CntLast) begin
                    cnt_next   = '0;
                    level_next = s2_reg[gi];
                    edge_next  = s2_reg[gi] ? EDGE_RISE : EDGE_FALL;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_reg   <= '0;
                level_reg <= ResetLevel;
                rise_reg  <= 1'b0;
                fall_reg  <= 1'b0;
            end else begin
                cnt_reg   <= cnt_next;
                level_reg <= level_next;
                rise_reg  <= (edge_next == EDGE_RISE);
                fall_reg  <= (edge_next == EDGE_FALL);
            end
        end

        assign btn_o[gi]  = level_reg;
        assign rise_o[gi] = rise_reg;
        assign fall_o[gi] = fall_reg;
    end

    assign tick_o = tick;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: a tick-counting reference model checks the main
// instance every cycle; two extra instances cover the edge parameters.
module tb_gpio_debounce;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_a = '0;
    logic [N-1:0] btn_b = '0;
    logic [N-1:0] btn_c = 3'b111;

    logic [N-1:0] a_btn, a_rise, a_fall;
    logic         a_tick;
    logic [N-1:0] b_btn, b_rise, b_fall;
    logic         b_tick;
    logic [N-1:0] c_btn, c_rise, c_fall;
    logic         c_tick;

    int checks = 0;
    int errors = 0;

    gpio_debounce #(.NumChannels(N), .TickDiv(TD), .StableTicks(ST), .ResetLevel(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_a), .btn_o(a_btn),
        .rise_o(a_rise), .fall_o(a_fall), .tick_o(a_tick));

    gpio_debounce #(.NumChannels(N), .TickDiv(1), .StableTicks(1), .ResetLevel(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_b), .btn_o(b_btn),
        .rise_o(b_rise), .fall_o(b_fall), .tick_o(b_tick));

    gpio_debounce #(.NumChannels(N), .TickDiv(TD), .StableTicks(ST), .ResetLevel(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_c), .btn_o(c_btn),
        .rise_o(c_rise), .fall_o(c_fall), .tick_o(c_tick));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ticks are seen at edge indices j >= 1 with j % TD == TD-1 (j = edges
    // since reset release); count those inside [a, b].
    function automatic int count_ticks(input int a, input int b);
        int c;
        c = (b + 1) / TD - a / TD;
        if (TD == 1 && a == 0) c--;
        return c;
    endfunction

    // Reference model: a level is accepted once a continuous run of
    // disagreement between the synchronised input and the output spans ST ticks.
    logic [N-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic         m_tick;
    int           e = 0;
    bit           run_act [N];
    int           run_start [N];

    always @(posedge clk) begin
        m_rise = '0;
        m_fall = '0;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_out = '0;
            e = 0;
            for (int c = 0; c < N; c++) run_act[c] = 1'b0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (m_s2[c] == m_out[c]) begin
                    run_act[c] = 1'b0;
                end else begin
                    if (!run_act[c]) begin
                        run_act[c]   = 1'b1;
                        run_start[c] = e;
                    end
                    if (count_ticks(run_start[c], e) == ST) begin
                        m_out[c] = m_s2[c];
                        if (m_s2[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                        run_act[c] = 1'b0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_a;
            e++;
        end
        m_tick = (e >= 1) && (e % TD == TD - 1);
        #1;
        check("model_btn",  32'(a_btn),  32'(m_out));
        check("model_rise", 32'(a_rise), 32'(m_rise));
        check("model_fall", 32'(a_fall), 32'(m_fall));
        check("model_tick", 32'(a_tick), 32'(m_tick));
        check("rl1_btn",    32'(c_btn),  32'(3'b111));
        check("rl1_fall",   32'(c_fall), 32'(3'b000));
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int  lat;
        int  cnt;
        bit  found;
        logic bad;

        // Reset held while inputs toggle.
        repeat (4) begin
            @(negedge clk) btn_a = btn_a ^ 3'b111;
            @(posedge clk); #1;
            check("rst_btn",  32'(a_btn),  32'(0));
            check("rst_rise", 32'(a_rise | a_fall), 32'(0));
            check("rst_tick", 32'(a_tick), 32'(0));
        end
        @(negedge clk) begin btn_a = '0; rst = 1'b0; end

        // Tick phase after release: high after 3, 7, 11 edges.
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("tick_phase", 32'(a_tick), 32'(k % 4 == 3));
            check("tick_div1",  32'(b_tick), 32'(1));
        end

        // Clean press on channel 0.
        @(negedge clk) btn_a[0] = 1'b1;
        lat = 0; cnt = 0; found = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (a_rise[0]) cnt++;
            if (!found && a_btn[0]) begin
                found = 1;
                lat = k;
                check("press_rise_aligned", 32'(a_rise[0]), 32'(1));
            end
        end
        check("press_latency_ok", 32'(lat >= 11 && lat <= 14), 32'(1));
        check("press_one_rise", 32'(cnt), 32'(1));

        // Bounce on channel 1: toggle every 5 cycles for 60 cycles.
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk) if (i % 5 == 0) btn_a[1] = ~btn_a[1];
            @(posedge clk); #1;
            bad = bad | a_btn[1] | a_rise[1] | a_fall[1];
        end
        check("bounce_quiet", 32'(bad), 32'(0));
        @(negedge clk) btn_a[1] = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (a_rise[1]) cnt++;
        end
        check("bounce_one_rise", 32'(cnt), 32'(1));
        check("bounce_settled", 32'(a_btn), 32'(3'b011));

        // Simultaneous release of channels 0 and 2.
        @(negedge clk) btn_a[2] = 1'b1;
        repeat (20) @(negedge clk);
        check("sim_all_high", 32'(a_btn), 32'(3'b111));
        btn_a[0] = 1'b0;
        btn_a[2] = 1'b0;
        found = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (!found && a_fall != '0) begin
                found = 1;
                check("sim_fall", 32'(a_fall), 32'(3'b101));
                check("sim_ch1_held", 32'(a_btn[1]), 32'(1));
            end
        end
        check("sim_fall_seen", 32'(found), 32'(1));

        // Reset with channel 0's counter at 2.
        @(negedge clk) btn_a[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check("midrst_btn", 32'(a_btn), 32'(0));
        check("midrst_rise", 32'(a_rise), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && a_rise[0]) lat = k;
        end
        check("midrst_reaccept_latency", 32'(lat), 32'(12));

        // TickDiv=1, StableTicks=1: output follows 3 edges after the step.
        @(negedge clk) btn_b[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("div1_step_btn",  32'(b_btn[0]),  32'(k >= 3));
            check("div1_step_rise", 32'(b_rise[0]), 32'(k == 3));
        end
        @(negedge clk) btn_b[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("div1_fall_btn",  32'(b_btn[0]),  32'(k < 3));
            check("div1_fall_pulse", 32'(b_fall[0]), 32'(k == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
